// File: rtl/io_bus_responder_pkg.sv
// Shared definitions for the I/O bus responder: bus access encodings, register
// addresses, interrupt source indices and the UART handshake state types.
package io_bus_responder_pkg;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [15:0] IO_DATA   = 16'hBF00;
    localparam logic [15:0] IO_STATUS = 16'hBF01;
    localparam logic [15:0] IO_TIMER  = 16'hBF02;
    localparam logic [15:0] IO_IRQ    = 16'hBF03;

    localparam logic [3:0] IRQ_NONE  = 4'd0;
    localparam logic [3:0] IRQ_TIMER = 4'd2;
    localparam logic [3:0] IRQ_RX    = 4'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_READ,
        RX_CAPTURE,
        RX_WAIT
    } rxState_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_STROBE,
        TX_RELEASE,
        TX_WAIT_TBRE,
        TX_WAIT_TSRE
    } txState_e;

    // All four registers live in one 4-byte-aligned window.
    function automatic logic inIoWindow(input logic [15:0] addr);
        return addr[15:2] == IO_DATA[15:2];
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Circular byte buffer for received UART data. Popping an empty buffer yields
// zero; a push and a pop in the same cycle are both honoured.
module io_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic [7:0] popData,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = empty ? 8'h00 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder on the CPU data port: UART RX/TX handshakes,
// a reload timer and the hardware interrupt request back into the CPU.
module io_bus_responder
    import io_bus_responder_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Aaddr,
    input  logic [1:0]  ExMemControl,
    input  logic [15:0] ExCalResult,
    output logic [15:0] ioReadData,
    output logic        ioHit,
    output logic        hardwareInterruptSignal,
    output logic [3:0]  hardwareInterruptIndex,
    input  logic        uartDataReady,
    input  logic        uartTbre,
    input  logic        uartTsre,
    input  logic [7:0]  uartDataIn,
    output logic [7:0]  uartDataOut,
    output logic        uartDataOe,
    output logic        uartRdn,
    output logic        uartWrn
);

    rxState_e    rxState;
    rxState_e    rxNext;
    txState_e    txState;
    txState_e    txNext;

    logic        isRead;
    logic        isWrite;
    logic        readHit;
    logic        selData;
    logic        selStatus;
    logic        selTimer;
    logic        selIrq;
    logic [15:0] readValue;

    logic        fifoPush;
    logic        fifoPop;
    logic [7:0]  fifoPopData;
    logic        fifoFull;
    logic        fifoEmpty;

    logic        txFull;
    logic [7:0]  txData;
    logic        txOverrun;
    logic        txReady;
    logic        txWrite;

    logic [15:0] timerReload;
    logic [15:0] timerCount;
    logic        timerPending;
    logic        timerWrite;
    logic        timerExpire;
    logic        irqWrite;
    logic [1:0]  irqEnable;
    logic        rxIrq;
    logic        tmIrq;

    assign isRead    = (ExMemControl == MEM_READ);
    assign isWrite   = (ExMemControl == MEM_WRITE);
    assign readHit   = isRead && inIoWindow(Aaddr);
    assign selData   = (Aaddr == IO_DATA);
    assign selStatus = (Aaddr == IO_STATUS);
    assign selTimer  = (Aaddr == IO_TIMER);
    assign selIrq    = (Aaddr == IO_IRQ);

    assign fifoPop    = isRead && selData;
    assign txWrite    = isWrite && selData;
    assign timerWrite = isWrite && selTimer;
    assign irqWrite   = isWrite && selIrq;
    assign txReady    = (txState == TX_IDLE) && !txFull;

    io_rx_fifo #(
        .DEPTH(RX_DEPTH)
    ) rxFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifoPush),
        .pushData(uartDataIn),
        .pop     (fifoPop),
        .popData (fifoPopData),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // Register read mux, sampled from the state before this cycle's edge.
    always_comb begin
        readValue = 16'h0000;
        if (selData) begin
            readValue = {8'h00, fifoPopData};
        end else if (selStatus) begin
            readValue = {12'h000, fifoFull, txOverrun, !fifoEmpty, txReady};
        end else if (selTimer) begin
            readValue = timerCount;
        end else if (selIrq) begin
            readValue = {10'h000, timerPending, 3'b000, irqEnable};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ioHit      <= 1'b0;
            ioReadData <= 16'h0000;
        end else begin
            ioHit      <= readHit;
            ioReadData <= readHit ? readValue : 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxState <= RX_IDLE;
        end else begin
            rxState <= rxNext;
        end
    end

    // The chip byte is sampled on the edge that ends the read strobe.
    always_comb begin
        rxNext   = rxState;
        uartRdn  = 1'b1;
        fifoPush = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (uartDataReady && !fifoFull) begin
                    rxNext = RX_READ;
                end
            end
            RX_READ: begin
                uartRdn  = 1'b0;
                fifoPush = 1'b1;
                rxNext   = RX_CAPTURE;
            end
            RX_CAPTURE: begin
                rxNext = RX_WAIT;
            end
            RX_WAIT: begin
                if (!uartDataReady) begin
                    rxNext = RX_IDLE;
                end
            end
            default: rxNext = RX_IDLE;
        endcase
    end

    // A write that finds the transmitter busy is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txFull    <= 1'b0;
            txData    <= 8'h00;
            txOverrun <= 1'b0;
        end else begin
            if (txState == TX_RELEASE) begin
                txFull <= 1'b0;
            end
            if (txWrite && txReady) begin
                txFull <= 1'b1;
                txData <= ExCalResult[7:0];
            end
            if (isWrite && selStatus && ExCalResult[2]) begin
                txOverrun <= 1'b0;
            end
            if (txWrite && !txReady) begin
                txOverrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState <= TX_IDLE;
        end else begin
            txState <= txNext;
        end
    end

    always_comb begin
        txNext     = txState;
        uartWrn    = 1'b1;
        uartDataOe = 1'b0;
        case (txState)
            TX_IDLE: begin
                if (txFull) begin
                    txNext = TX_SETUP;
                end
            end
            TX_SETUP: begin
                uartDataOe = 1'b1;
                txNext     = TX_STROBE;
            end
            TX_STROBE: begin
                uartDataOe = 1'b1;
                uartWrn    = 1'b0;
                txNext     = TX_RELEASE;
            end
            TX_RELEASE: begin
                uartDataOe = 1'b1;
                txNext     = TX_WAIT_TBRE;
            end
            TX_WAIT_TBRE: begin
                if (uartTbre) begin
                    txNext = TX_WAIT_TSRE;
                end
            end
            TX_WAIT_TSRE: begin
                if (uartTsre) begin
                    txNext = TX_IDLE;
                end
            end
            default: txNext = TX_IDLE;
        endcase
    end

    assign uartDataOut = txData;

    // A CPU write to the timer overrides an expiry landing on the same edge.
    assign timerExpire = !timerWrite && (timerReload != 16'h0000) && (timerCount == 16'h0001);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timerReload  <= 16'h0000;
            timerCount   <= 16'h0000;
            timerPending <= 1'b0;
            irqEnable    <= 2'b00;
        end else begin
            if (timerWrite) begin
                timerReload <= ExCalResult;
                timerCount  <= ExCalResult;
            end else if (timerExpire) begin
                timerCount <= timerReload;
            end else if (timerReload != 16'h0000) begin
                timerCount <= timerCount - 16'h0001;
            end
            if (irqWrite) begin
                irqEnable <= ExCalResult[1:0];
                if (ExCalResult[5]) begin
                    timerPending <= 1'b0;
                end
            end
            if (timerExpire) begin
                timerPending <= 1'b1;
            end
        end
    end

    assign rxIrq = !fifoEmpty && irqEnable[0];
    assign tmIrq = timerPending && irqEnable[1];

    // Receive data outranks the timer when both are requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hardwareInterruptSignal <= 1'b0;
            hardwareInterruptIndex  <= IRQ_NONE;
        end else begin
            hardwareInterruptSignal <= rxIrq || tmIrq;
            hardwareInterruptIndex  <= rxIrq ? IRQ_RX : (tmIrq ? IRQ_TIMER : IRQ_NONE);
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed scenarios plus randomized
// register traffic checked against a queue-based model of the register map.
module tb_io_bus_responder;

    localparam logic [15:0] A_DATA   = 16'hBF00;
    localparam logic [15:0] A_STATUS = 16'hBF01;
    localparam logic [15:0] A_TIMER  = 16'hBF02;
    localparam logic [15:0] A_IRQ    = 16'hBF03;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic [15:0] Aaddr;
    logic [1:0]  ExMemControl;
    logic [15:0] ExCalResult;
    logic [15:0] ioReadData;
    logic        ioHit;
    logic        hardwareInterruptSignal;
    logic [3:0]  hardwareInterruptIndex;
    logic        uartDataReady;
    logic        uartTbre;
    logic        uartTsre;
    logic [7:0]  uartDataIn;
    logic [7:0]  uartDataOut;
    logic        uartDataOe;
    logic        uartRdn;
    logic        uartWrn;

    int          checks = 0;
    int          passes = 0;
    int unsigned cyc = 0;
    int          wrnLows = 0;
    int          oeCycles = 0;
    int          rdnLows = 0;
    logic [7:0]  lastTxByte = 8'h00;

    logic [7:0]  rxQ[$];
    logic [1:0]  enM = 2'b00;

    io_bus_responder #(.RX_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .Aaddr                  (Aaddr),
        .ExMemControl           (ExMemControl),
        .ExCalResult            (ExCalResult),
        .ioReadData             (ioReadData),
        .ioHit                  (ioHit),
        .hardwareInterruptSignal(hardwareInterruptSignal),
        .hardwareInterruptIndex (hardwareInterruptIndex),
        .uartDataReady          (uartDataReady),
        .uartTbre               (uartTbre),
        .uartTsre               (uartTsre),
        .uartDataIn             (uartDataIn),
        .uartDataOut            (uartDataOut),
        .uartDataOe             (uartDataOe),
        .uartRdn                (uartRdn),
        .uartWrn                (uartWrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and drive-enable activity as seen by the UART chip.
    always @(negedge clk) begin
        if (!uartWrn) begin
            wrnLows++;
            lastTxByte = uartDataOut;
        end
        if (uartDataOe) oeCycles++;
        if (!uartRdn) rdnLows++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] expStatus();
        return {12'h000, rxQ.size() == DEPTH, 1'b0, rxQ.size() != 0, 1'b1};
    endfunction

    function automatic logic [3:0] expIndex();
        return (rxQ.size() != 0 && enM[0]) ? 4'd3 : 4'd0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [15:0] data);
        Aaddr = addr;
        ExCalResult = data;
        ExMemControl = 2'b10;
        @(posedge clk);
        #1;
        ExMemControl = 2'b00;
    endtask

    task automatic doRead(input logic [15:0] addr, output logic [15:0] data, output logic hit);
        Aaddr = addr;
        ExMemControl = 2'b01;
        @(posedge clk);
        #1;
        data = ioReadData;
        hit = ioHit;
        ExMemControl = 2'b00;
    endtask

    task automatic sendRxByte(input logic [7:0] b);
        uartDataIn = b;
        uartDataReady = 1'b1;
        for (int i = 0; i < 8 && uartRdn; i++) idle(1);
        checks++;
        if (uartRdn !== 1'b0) $display("[TB] FAIL rx_handshake: uartRdn got %b, expected 0 within 8 cycles", uartRdn);
        else passes++;
        idle(1);
        uartDataReady = 1'b0;
        idle(2);
        rxQ.push_back(b);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic h;
        rst = 1'b0;
        Aaddr = 16'h0000;
        ExMemControl = 2'b00;
        ExCalResult = 16'h0000;
        uartDataReady = 1'b0;
        uartTbre = 1'b0;
        uartTsre = 1'b0;
        uartDataIn = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uartRdn !== 1'b1 || uartWrn !== 1'b1) $display("[TB] FAIL reset_strobes: rdn/wrn got %b%b, expected 11", uartRdn, uartWrn);
        else passes++;
        checks++;
        if (uartDataOe !== 1'b0 || uartDataOut !== 8'h00) $display("[TB] FAIL reset_bus: oe/out got %b/%h, expected 0/00", uartDataOe, uartDataOut);
        else passes++;
        rst = 1'b1;
        idle(2);
        checks++;
        if (hardwareInterruptSignal !== 1'b0 || hardwareInterruptIndex !== 4'd0) $display("[TB] FAIL reset_irq: sig/idx got %b/%0d, expected 0/0", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
        checks++;
        if (ioHit !== 1'b0 || ioReadData !== 16'h0000) $display("[TB] FAIL reset_read: hit/data got %b/%h, expected 0/0000", ioHit, ioReadData);
        else passes++;
        doRead(A_STATUS, d, h);
        checks++;
        if (h !== 1'b1 || d !== 16'h0001) $display("[TB] FAIL reset_status: hit/data got %b/%h, expected 1/0001", h, d);
        else passes++;
        doRead(A_TIMER, d, h);
        checks++;
        if (d !== 16'h0000) $display("[TB] FAIL reset_timer: got %h, expected 0000", d);
        else passes++;
        doRead(A_IRQ, d, h);
        checks++;
        if (d !== 16'h0000) $display("[TB] FAIL reset_irqreg: got %h, expected 0000", d);
        else passes++;
    endtask

    task automatic test_tx();
        logic [15:0] d;
        logic h;
        logic [7:0] b;
        int wrn0;
        int oe0;
        wrn0 = wrnLows;
        oe0 = oeCycles;
        doWrite(A_DATA, 16'h0041);
        for (int i = 0; i < 4 && !uartDataOe; i++) idle(1);
        checks++;
        if (uartDataOe !== 1'b1 || uartDataOut !== 8'h41) $display("[TB] FAIL tx_setup: oe/out got %b/%h, expected 1/41", uartDataOe, uartDataOut);
        else passes++;
        idle(4);
        checks++;
        if (wrnLows - wrn0 != 1 || lastTxByte !== 8'h41) $display("[TB] FAIL tx_strobe: pulses/byte got %0d/%h, expected 1/41", wrnLows - wrn0, lastTxByte);
        else passes++;
        checks++;
        if (oeCycles - oe0 != 3 || uartDataOe !== 1'b0) $display("[TB] FAIL tx_oe_window: cycles/oe got %0d/%b, expected 3/0", oeCycles - oe0, uartDataOe);
        else passes++;
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0000) $display("[TB] FAIL tx_busy_status: got %h, expected 0000", d);
        else passes++;
        doWrite(A_DATA, 16'h0042);
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0004) $display("[TB] FAIL tx_overrun_status: got %h, expected 0004", d);
        else passes++;
        idle(4);
        checks++;
        if (wrnLows - wrn0 != 1) $display("[TB] FAIL tx_no_second_strobe: pulses got %0d, expected 1", wrnLows - wrn0);
        else passes++;
        uartTbre = 1'b1;
        uartTsre = 1'b1;
        idle(3);
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0005) $display("[TB] FAIL tx_idle_status: got %h, expected 0005", d);
        else passes++;
        doWrite(A_STATUS, 16'h0004);
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0001) $display("[TB] FAIL tx_overrun_clear: got %h, expected 0001", d);
        else passes++;
        // A write landing while the buffer is being released counts as an overrun.
        b = 8'($urandom_range(0, 255));
        wrn0 = wrnLows;
        doWrite(A_DATA, {8'h00, b});
        idle(3);
        doWrite(A_DATA, {8'h00, ~b});
        idle(6);
        checks++;
        if (wrnLows - wrn0 != 1 || lastTxByte !== b) $display("[TB] FAIL tx_release_race: pulses/byte got %0d/%h, expected 1/%h", wrnLows - wrn0, lastTxByte, b);
        else passes++;
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0005) $display("[TB] FAIL tx_release_overrun: got %h, expected 0005", d);
        else passes++;
        doWrite(A_STATUS, 16'h0004);
    endtask

    task automatic test_rx();
        logic [15:0] d;
        logic h;
        doWrite(A_IRQ, 16'h0001);
        enM = 2'b01;
        sendRxByte(8'h5A);
        checks++;
        if (hardwareInterruptSignal !== 1'b1 || hardwareInterruptIndex !== 4'd3) $display("[TB] FAIL rx_irq: sig/idx got %b/%0d, expected 1/3", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
        doRead(A_DATA, d, h);
        checks++;
        if (h !== 1'b1 || d !== {8'h00, rxQ.pop_front()}) $display("[TB] FAIL rx_read: hit/data got %b/%h, expected 1/005a", h, d);
        else passes++;
        checks++;
        if (hardwareInterruptSignal !== 1'b1) $display("[TB] FAIL rx_irq_lag: sig got %b, expected 1", hardwareInterruptSignal);
        else passes++;
        idle(1);
        checks++;
        if (hardwareInterruptSignal !== 1'b0 || hardwareInterruptIndex !== 4'd0) $display("[TB] FAIL rx_irq_drop: sig/idx got %b/%0d, expected 0/0", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic h;
        logic [7:0] b;
        int rdn0;
        for (int i = 0; i < DEPTH; i++) sendRxByte(8'($urandom_range(0, 255)));
        b = 8'($urandom_range(0, 255));
        rdn0 = rdnLows;
        uartDataIn = b;
        uartDataReady = 1'b1;
        idle(8);
        checks++;
        if (rdnLows != rdn0 || uartRdn !== 1'b1) $display("[TB] FAIL bp_hold: rdn pulses/level got %0d/%b, expected 0/1", rdnLows - rdn0, uartRdn);
        else passes++;
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== expStatus()) $display("[TB] FAIL bp_status: got %h, expected %h", d, expStatus());
        else passes++;
        doRead(A_DATA, d, h);
        checks++;
        if (d !== {8'h00, rxQ.pop_front()}) $display("[TB] FAIL bp_pop: got %h", d);
        else passes++;
        for (int i = 0; i < 8 && uartRdn; i++) idle(1);
        checks++;
        if (uartRdn !== 1'b0) $display("[TB] FAIL bp_resume: uartRdn got %b, expected 0", uartRdn);
        else passes++;
        idle(1);
        uartDataReady = 1'b0;
        idle(2);
        rxQ.push_back(b);
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] e;
            e = rxQ.pop_front();
            doRead(A_DATA, d, h);
            checks++;
            if (h !== 1'b1 || d !== {8'h00, e}) $display("[TB] FAIL bp_drain%0d: got %h, expected %h", i, d, {8'h00, e});
            else passes++;
        end
        doRead(A_DATA, d, h);
        checks++;
        if (h !== 1'b1 || d !== 16'h0000) $display("[TB] FAIL bp_empty_read: hit/data got %b/%h, expected 1/0000", h, d);
        else passes++;
    endtask

    task automatic test_timer();
        logic [15:0] d;
        logic h;
        logic [15:0] r;
        int unsigned wc;
        int unsigned kPre;
        logic e;
        doWrite(A_IRQ, 16'h0002);
        enM = 2'b10;
        r = 16'd3;
        doWrite(A_TIMER, r);
        wc = cyc;
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            e = (k >= 4);
            checks++;
            if (hardwareInterruptSignal !== e || hardwareInterruptIndex !== (e ? 4'd2 : 4'd0)) $display("[TB] FAIL timer_irq_k%0d: sig/idx got %b/%0d, expected %b", k, hardwareInterruptSignal, hardwareInterruptIndex, e);
            else passes++;
        end
        repeat (4) begin
            idle($urandom_range(0, 4));
            kPre = cyc - wc;
            doRead(A_TIMER, d, h);
            checks++;
            if (d !== r - 16'(kPre % r)) $display("[TB] FAIL timer_count: got %0d, expected %0d", d, r - 16'(kPre % r));
            else passes++;
        end
        if ((cyc + 1 - wc) % r == 0) idle(1);
        doWrite(A_IRQ, 16'h0022);
        doRead(A_IRQ, d, h);
        checks++;
        if (d !== 16'h0002) $display("[TB] FAIL timer_clear: got %h, expected 0002", d);
        else passes++;
        for (int i = 0; i < 4 && (cyc + 1 - wc) % r != 0; i++) idle(1);
        doWrite(A_IRQ, 16'h0022);
        doRead(A_IRQ, d, h);
        checks++;
        if (d !== 16'h0022) $display("[TB] FAIL timer_set_beats_clear: got %h, expected 0022", d);
        else passes++;
        if ((cyc + 1 - wc) % r == 0) idle(1);
        doWrite(A_IRQ, 16'h0022);
        for (int i = 0; i < 4 && (cyc + 1 - wc) % r != 0; i++) idle(1);
        r = 16'($urandom_range(4, 7));
        doWrite(A_TIMER, r);
        wc = cyc;
        doRead(A_IRQ, d, h);
        checks++;
        if (d !== 16'h0002) $display("[TB] FAIL timer_write_beats_expiry: got %h, expected 0002", d);
        else passes++;
        idle($urandom_range(0, 10));
        kPre = cyc - wc;
        doRead(A_TIMER, d, h);
        checks++;
        if (d !== r - 16'(kPre % r)) $display("[TB] FAIL timer_count_new: got %0d, expected %0d", d, r - 16'(kPre % r));
        else passes++;
        doWrite(A_TIMER, 16'h0000);
        doWrite(A_IRQ, 16'h0022);
        idle(5);
        doRead(A_TIMER, d, h);
        checks++;
        if (d !== 16'h0000) $display("[TB] FAIL timer_stopped_count: got %h, expected 0000", d);
        else passes++;
        doRead(A_IRQ, d, h);
        checks++;
        if (d !== 16'h0002) $display("[TB] FAIL timer_stopped_pending: got %h, expected 0002", d);
        else passes++;
    endtask

    task automatic test_priority();
        logic [15:0] d;
        logic h;
        logic [7:0] b;
        doWrite(A_IRQ, 16'h0003);
        enM = 2'b11;
        doWrite(A_TIMER, 16'd2);
        idle(4);
        b = 8'($urandom_range(0, 255));
        sendRxByte(b);
        checks++;
        if (hardwareInterruptSignal !== 1'b1 || hardwareInterruptIndex !== 4'd3) $display("[TB] FAIL prio_both: sig/idx got %b/%0d, expected 1/3", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
        doWrite(A_TIMER, 16'h0000);
        doRead(A_DATA, d, h);
        checks++;
        if (d !== {8'h00, rxQ.pop_front()}) $display("[TB] FAIL prio_read: got %h, expected %h", d, {8'h00, b});
        else passes++;
        idle(1);
        checks++;
        if (hardwareInterruptSignal !== 1'b1 || hardwareInterruptIndex !== 4'd2) $display("[TB] FAIL prio_timer_left: sig/idx got %b/%0d, expected 1/2", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
        doWrite(A_IRQ, 16'h0020);
        enM = 2'b00;
        idle(2);
        checks++;
        if (hardwareInterruptSignal !== 1'b0 || hardwareInterruptIndex !== 4'd0) $display("[TB] FAIL prio_quiet: sig/idx got %b/%0d, expected 0/0", hardwareInterruptSignal, hardwareInterruptIndex);
        else passes++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic h;
        logic [15:0] a;
        logic [15:0] v;
        int op;
        for (int n = 0; n < 50; n++) begin
            op = $urandom_range(0, 5);
            if (op == 0 && rxQ.size() == DEPTH) op = 1;
            case (op)
                0: sendRxByte(8'($urandom_range(0, 255)));
                1: begin
                    v = (rxQ.size() != 0) ? {8'h00, rxQ.pop_front()} : 16'h0000;
                    doRead(A_DATA, d, h);
                    checks++;
                    if (h !== 1'b1 || d !== v) $display("[TB] FAIL rand_data: hit/data got %b/%h, expected 1/%h", h, d, v);
                    else passes++;
                end
                2: begin
                    doRead(A_STATUS, d, h);
                    checks++;
                    if (d !== expStatus()) $display("[TB] FAIL rand_status: got %h, expected %h", d, expStatus());
                    else passes++;
                end
                3: begin
                    v = 16'($urandom);
                    doWrite(A_IRQ, v);
                    enM = v[1:0];
                end
                4: begin
                    do a = 16'($urandom); while (a[15:2] == 14'h2FC0);
                    if ($urandom_range(0, 1) == 1) begin
                        doWrite(a, 16'($urandom));
                    end else begin
                        doRead(a, d, h);
                        checks++;
                        if (h !== 1'b0 || d !== 16'h0000) $display("[TB] FAIL rand_outside: hit/data got %b/%h, expected 0/0000", h, d);
                        else passes++;
                    end
                end
                default: begin
                    doRead(A_IRQ, d, h);
                    checks++;
                    if (d !== {14'h0000, enM}) $display("[TB] FAIL rand_irqreg: got %h, expected %h", d, {14'h0000, enM});
                    else passes++;
                end
            endcase
            idle(1);
            checks++;
            if (hardwareInterruptIndex !== expIndex() || hardwareInterruptSignal !== (expIndex() != 4'd0)) $display("[TB] FAIL rand_irq: sig/idx got %b/%0d, expected idx %0d", hardwareInterruptSignal, hardwareInterruptIndex, expIndex());
            else passes++;
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] d;
        logic h;
        doWrite(A_DATA, 16'h00C3);
        idle(2);
        checks++;
        if (uartWrn !== 1'b0) $display("[TB] FAIL midrst_strobe: uartWrn got %b, expected 0", uartWrn);
        else passes++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (uartWrn !== 1'b1 || uartDataOe !== 1'b0 || uartRdn !== 1'b1) $display("[TB] FAIL midrst_release: wrn/oe/rdn got %b/%b/%b, expected 1/0/1", uartWrn, uartDataOe, uartRdn);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rxQ.delete();
        enM = 2'b00;
        idle(1);
        doRead(A_STATUS, d, h);
        checks++;
        if (d !== 16'h0001) $display("[TB] FAIL midrst_status: got %h, expected 0001", d);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_backpressure();
        test_timer();
        test_priority();
        test_random();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
